instr_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/fetch_fifo.sv | 96 +++++++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode map and instruction field layout.
// Used by both the fetch unit and the execute core.
package cpu_pkg;

    localparam int INSTR_W = 19;
    localparam int ADDR_W  = 14;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_XOR  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_BNE  = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_CALL = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_RET  = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_MOV  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_PUSH = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_POP  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_INC  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_DEC  = 5'b10011;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;  // [18:14]
        logic [3:0]       rd;      // [13:10]
        logic [3:0]       rs;      // [9:6]
        logic [5:0]       lo;      // [5:0]
    } instr_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Opcodes for which the core drives the redirect port.
    function automatic logic is_redirect_op(input logic [OPC_W-1:0] opc);
        return (opc >= OPC_JMP) && (opc <= OPC_RET);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {addr,instr} entries with a registered head and a synchronous clear.
// The head register is loaded directly from push data when the FIFO is (or becomes) empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output logic                     o_head_valid,
    output fetch_entry_t             o_head_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_head_valid;
    fetch_entry_t       r_head_data;

    logic               w_pop;
    logic               w_push;
    logic [PTR_W-1:0]   w_rd_next;
    logic [PTR_W:0]     w_count_next;
    logic               w_head_valid_next;
    fetch_entry_t       w_head_next;

    // Next pointer/count and next head entry; the slot being written this cycle is bypassed.
    always_comb begin
        w_pop  = i_pop && r_head_valid;
        w_push = i_push && ((r_count != FULL_C) || w_pop);
        if (w_pop) begin
            w_rd_next = r_rd_ptr + PTR_W'(1'b1);
        end else begin
            w_rd_next = r_rd_ptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W+1)'(1'b1);
            2'b01:   w_count_next = r_count - (PTR_W+1)'(1'b1);
            default: w_count_next = r_count;
        endcase
        w_head_valid_next = (w_count_next != '0);
        if (!w_head_valid_next) begin
            w_head_next = '0;
        end else if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_next = i_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Entry storage; contents are don't-care once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else if (i_clear) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
            r_rd_ptr     <= w_rd_next;
            r_count      <= w_count_next;
            r_head_valid <= w_head_valid_next;
            r_head_data  <= w_head_next;
        end
    end

    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;
    assign o_count      = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-based issue to a 1-cycle synchronous instruction memory,
// and redirect/flush handling in front of the prefetch FIFO.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 14'd0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_inflight;
    logic              r_discard;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    // Credit counts the in-flight word so the FIFO can always absorb it; a pop never refunds same-cycle.
    always_comb begin
        w_credit    = w_count + {{(CNT_W-1){1'b0}}, r_inflight};
        w_issue     = !rst && !redirect_valid && (w_credit < DEPTH_C);
        w_push      = r_inflight && !r_discard && !redirect_valid;
        w_pop       = w_head_valid && instr_ready && !redirect_valid;
        w_push_data = '{addr: r_req_addr, instr: imem_rdata};
    end

    // PC and request-tracking flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_pc <= redirect_addr;
            end else if (w_issue) begin
                r_pc <= r_pc + 14'd1;
            end
            if (w_issue) begin
                r_req_addr <= r_pc;
            end
            r_inflight <= w_issue;
            r_discard  <= redirect_valid && r_inflight;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (redirect_valid),
        .i_push       (w_push),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head),
        .o_count      (w_count)
    );

    assign imem_en     = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = w_head_valid;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.addr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit; the model tracks the next
// address the consumer must see and derives the expected word from the memory image.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [18:0] imem_rdata = 19'd0;
    logic        instr_valid;
    logic [18:0] instr;
    logic [13:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [13:0] redirect_addr;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_issue = 0;
    int          n_pop = 0;
    logic [13:0] e_pc;
    logic [13:0] got[$];

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(14'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mem_word(input logic [13:0] a);
        return 19'(a) + 19'd100;
    endfunction

    // Memory image: word k = k+100, garbage on cycles without a request.
    always @(posedge clk) begin
        if (imem_en === 1'b1) imem_rdata <= mem_word(imem_addr);
        else                  imem_rdata <= 19'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the head against the model at negedge, then advance the model.
    task automatic tick();
        @(negedge clk);
        if (instr_valid === 1'b1) begin
            chk("head_pc", 32'(instr_pc), 32'(e_pc));
            chk("head_instr", 32'(instr), 32'(mem_word(e_pc)));
        end else begin
            chk("empty_instr", 32'(instr), 32'd0);
            chk("empty_pc", 32'(instr_pc), 32'd0);
        end
        if (imem_en === 1'b1) n_issue++;
        if (redirect_valid) begin
            e_pc = redirect_addr;
        end else if (instr_valid === 1'b1 && instr_ready) begin
            got.push_back(instr_pc);
            n_pop++;
            e_pc = e_pc + 14'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e_pc = 14'd0;
        got.delete();
    endtask

    initial begin
        int pops_before;
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = 14'd0;
        e_pc = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_en", 32'(imem_en), 32'd1);
        chk("rel_addr", 32'(imem_addr), 32'd0);

        // Streaming from reset
        instr_ready = 1'b1;
        tick();
        chk("lat_edge1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("lat_edge2_valid", 32'(instr_valid), 32'd1);
        chk("lat_edge2_pc", 32'(instr_pc), 32'd0);
        chk("lat_edge2_instr", 32'(instr), 32'd100);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stream_valid", 32'(instr_valid), 32'd1);
        end
        chk("stream_pc", 32'(instr_pc), 32'd10);

        // Fill with ready low
        do_reset();
        instr_ready = 1'b0;
        n_issue = 0;
        repeat (10) tick();
        chk("full_issues", 32'(n_issue), 32'd4);
        chk("full_en_low", 32'(imem_en), 32'd0);
        chk("full_head_pc", 32'(instr_pc), 32'd0);
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("drain_valid", 32'(instr_valid), 32'd1);
        end
        chk("drain_pc", 32'(instr_pc), 32'd12);

        // Redirect with 3 queued and 1 in flight
        do_reset();
        instr_ready = 1'b0;
        repeat (4) tick();
        chk("rd_pre_en", 32'(imem_en), 32'd0);
        chk("rd_pre_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_addr = 14'd30;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("rd_edge1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("rd_edge2_valid", 32'(instr_valid), 32'd1);
        chk("rd_edge2_pc", 32'(instr_pc), 32'd30);
        instr_ready = 1'b1;
        repeat (5) tick();

        // Back-to-back redirects
        redirect_valid = 1'b1;
        redirect_addr = 14'd40;
        tick();
        redirect_addr = 14'd60;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("b2b_edge1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("b2b_valid", 32'(instr_valid), 32'd1);
        chk("b2b_pc", 32'(instr_pc), 32'd60);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_addr = 14'd16382;
        tick();
        redirect_valid = 1'b0;
        got.delete();
        repeat (6) tick();
        chk("wrap_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("wrap_pc0", 32'(got[0]), 32'd16382);
            chk("wrap_pc1", 32'(got[1]), 32'd16383);
            chk("wrap_pc2", 32'(got[2]), 32'd0);
            chk("wrap_pc3", 32'(got[3]), 32'd1);
        end

        // Reset mid-stream with a full FIFO
        instr_ready = 1'b0;
        repeat (8) tick();
        chk("mid_full_valid", 32'(instr_valid), 32'd1);
        do_reset();
        instr_ready = 1'b1;
        tick();
        chk("mid_edge1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("mid_edge2_valid", 32'(instr_valid), 32'd1);
        chk("mid_edge2_pc", 32'(instr_pc), 32'd0);
        chk("mid_edge2_instr", 32'(instr), 32'd100);

        // Random ready/redirect traffic
        pops_before = n_pop;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(29, 0) == 0);
            redirect_addr = 14'($urandom);
            tick();
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (6) tick();
        chk("rand_progress", 32'((n_pop - pops_before) > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
